osc_envelope_vca: RTL and testbench
===================================

Name: osc_envelope_vca

Overview:
Downstream stage of the oscillator core. It takes the selected waveform sample stream and applies an ADSR amplitude envelope driven by a gate input. The result is a scaled waveform for the mixer/DAC path. Internally it has an ADSR state machine that advances once per sample strobe, plus a 2-stage multiply pipeline (the VCA).

Parameters:
- WAVE_WIDTH_P, 24, width of input/output samples; signed two's complement.
- ENV_WIDTH_P, 16, envelope level resolution; unsigned; full scale = 2^ENV_WIDTH_P-1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- waveform_in  input  WAVE_WIDTH_P  signed sample from oscillator core
- waveform_valid  input  1  one-clk strobe, new sample present (sample tick)
- gate  input  1  note on (1) / off (0), synchronous to clk
- cr_attack_step  input  ENV_WIDTH_P  level increment per sample in ATTACK
- cr_decay_step  input  ENV_WIDTH_P  level decrement per sample in DECAY
- cr_sustain_level  input  ENV_WIDTH_P  SUSTAIN hold level
- cr_release_step  input  ENV_WIDTH_P  level decrement per sample in RELEASE
- waveform_out  output  WAVE_WIDTH_P  signed enveloped sample
- waveform_out_valid  output  1  one-clk strobe for waveform_out
- env_level  output  ENV_WIDTH_P  current envelope level
- env_state  output  3  current osc_env_state_t
- env_busy  output  1  high when env_state != IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; internal gate_q 0.
- Gate edges are detected each clk against registered gate_q.
  - Gate high at reset release gives a rising edge on the first clk.
- Rising edge, from any state: go to ATTACK. Level is kept (legato retrigger, no jump to 0).
- Falling edge, from ATTACK/DECAY/SUSTAIN: go to RELEASE. A falling edge in IDLE/RELEASE is ignored.
- In a cycle with a gate edge, the state change wins and the level holds, even if waveform_valid=1.
- Level updates occur only on waveform_valid cycles without a gate edge:
  - ATTACK: level+step saturates at MAX=2^ENV_WIDTH_P-1. On reaching MAX, go to DECAY.
  - DECAY: if level-step <= sustain (computed with borrow, no wrap), level=sustain and go to SUSTAIN. Otherwise level-=step.
  - SUSTAIN: level tracks cr_sustain_level every clk, so live register changes apply immediately.
  - RELEASE: if step >= level, level=0 and go to IDLE. Otherwise level-=step.
  - IDLE: level holds 0.
- A step value of 0 means an instantaneous segment on the next strobe:
  - attack: MAX
  - decay: sustain
  - release: 0
- Sustain at or above the current level on DECAY entry: the next strobe sets level=sustain and goes to SUSTAIN.
- VCA pipeline, latency exactly 2 clk from waveform_valid to waveform_out_valid; back-to-back strobes are supported:
  - Stage 1 registers the signed product waveform_in * $signed({1'b0, env_level}), where env_level is the value before that cycle's update. Product width is WAVE_WIDTH_P+ENV_WIDTH_P+1.
  - Stage 2 registers product >>> ENV_WIDTH_P, truncated to WAVE_WIDTH_P. No overflow is possible because level <= MAX < 2^ENV_WIDTH_P.
  - waveform_out holds its value between strobes.
- Asynchronous reset mid-note: immediate IDLE, level 0, pipeline valids cleared. No sample is emitted after reset from in-flight data.

Decomposition:
- Add to oscillator_types_pkg:
  - typedef enum logic [2:0] osc_env_state_t: ENV_IDLE_E=0, ENV_ATTACK_E=1, ENV_DECAY_E=2, ENV_SUSTAIN_E=3, ENV_RELEASE_E=4.
- Sub-module osc_adsr contains the FSM and level register: gate, strobe and cr_* inputs; env_level and env_state outputs.
- osc_envelope_vca instantiates osc_adsr and contains the 2-stage multiply pipeline.

Test Plan:
All scenarios use defaults (MAX=65535).
1. Reset with gate=0, strobes running -> env_state=IDLE, env_level=0, waveform_out=0, waveform_out_valid pulses 2 clk after each strobe.
2. attack=16384, decay=8192, sustain=40000, gate rises, then strobes -> level 16384, 32768, 49152, 65535 (state DECAY), 57343, 49151, 40959, 40000 (state SUSTAIN).
3. In SUSTAIN at 40000, release=15000, gate falls -> RELEASE; strobes give 25000, 10000, 0; state IDLE, env_busy=0.
4. Level 32768 with waveform_in=+1000 at a strobe -> waveform_out=500, two clk later. With waveform_in=-1000 -> waveform_out=-500 (arithmetic shift, floor).
5. Gate rise and strobe in the same clk during RELEASE at level 20000 -> state ATTACK, level stays 20000 that cycle; next strobe gives 20000+attack_step.
6. All steps 0, gate rise, strobe -> level 65535; next strobe -> sustain. Assert rst_n mid-DECAY -> IDLE, level 0, no waveform_out_valid until a new strobe.

Source files
------------

// File: rtl/oscillator_types_pkg.sv
// Shared types for the oscillator core and its downstream stages.
package oscillator_types_pkg;

  // Envelope generator phase, also exported on the env_state port.
  typedef enum logic [2:0] {
    ENV_IDLE_E    = 3'd0,
    ENV_ATTACK_E  = 3'd1,
    ENV_DECAY_E   = 3'd2,
    ENV_SUSTAIN_E = 3'd3,
    ENV_RELEASE_E = 3'd4
  } osc_env_state_t;

  localparam int OSC_WAVE_WIDTH_C = 24;
  localparam int OSC_ENV_WIDTH_C  = 16;

  // True while the envelope is producing a non-idle contour.
  function automatic logic env_state_active(input osc_env_state_t s);
    return (s != ENV_IDLE_E);
  endfunction

endpackage

// File: rtl/osc_adsr.sv
// ADSR envelope generator: gate edge detection, phase FSM and level register.
// The level only moves on sample strobes, except in SUSTAIN where it follows
// the live sustain register every clock.
module osc_adsr
  import oscillator_types_pkg::*;
#(
  parameter int ENV_WIDTH_P = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   gate,
  input  logic                   strobe,
  input  logic [ENV_WIDTH_P-1:0] cr_attack_step,
  input  logic [ENV_WIDTH_P-1:0] cr_decay_step,
  input  logic [ENV_WIDTH_P-1:0] cr_sustain_level,
  input  logic [ENV_WIDTH_P-1:0] cr_release_step,
  output logic [ENV_WIDTH_P-1:0] env_level,
  output osc_env_state_t         env_state
);

  // Full-scale level, zero-extended by one bit so carry/borrow stays visible.
  localparam logic [ENV_WIDTH_P:0] MAX_EXT_C = {1'b0, {ENV_WIDTH_P{1'b1}}};
  localparam logic [ENV_WIDTH_P-1:0] MAX_C   = {ENV_WIDTH_P{1'b1}};

  logic                   gate_q;
  logic                   gate_d;
  osc_env_state_t         state_q;
  osc_env_state_t         state_d;
  logic [ENV_WIDTH_P-1:0] level_q;
  logic [ENV_WIDTH_P-1:0] level_d;

  logic                   gate_rise;
  logic                   gate_fall;
  logic [ENV_WIDTH_P:0]   attack_sum;
  logic [ENV_WIDTH_P:0]   decay_diff;

  // Next phase and level; a gate edge always takes priority over level motion.
  always_comb begin
    gate_d     = gate;
    state_d    = state_q;
    level_d    = level_q;
    gate_rise  = gate & ~gate_q;
    gate_fall  = ~gate & gate_q;
    attack_sum = {1'b0, level_q} + {1'b0, cr_attack_step};
    decay_diff = {1'b0, level_q} - {1'b0, cr_decay_step};

    if (gate_rise) begin
      // Legato retrigger: restart the attack from wherever the level is.
      state_d = ENV_ATTACK_E;
    end else if (gate_fall) begin
      if (state_q == ENV_ATTACK_E || state_q == ENV_DECAY_E ||
          state_q == ENV_SUSTAIN_E) begin
        state_d = ENV_RELEASE_E;
      end
    end else begin
      case (state_q)
        ENV_IDLE_E: begin
          level_d = '0;
        end
        ENV_ATTACK_E: begin
          if (strobe) begin
            if (cr_attack_step == '0 || attack_sum >= MAX_EXT_C) begin
              level_d = MAX_C;
              state_d = ENV_DECAY_E;
            end else begin
              level_d = attack_sum[ENV_WIDTH_P-1:0];
            end
          end
        end
        ENV_DECAY_E: begin
          if (strobe) begin
            // A borrow means the step overshot below zero, hence below sustain.
            if (cr_decay_step == '0 || decay_diff[ENV_WIDTH_P] ||
                decay_diff[ENV_WIDTH_P-1:0] <= cr_sustain_level) begin
              level_d = cr_sustain_level;
              state_d = ENV_SUSTAIN_E;
            end else begin
              level_d = decay_diff[ENV_WIDTH_P-1:0];
            end
          end
        end
        ENV_SUSTAIN_E: begin
          level_d = cr_sustain_level;
        end
        ENV_RELEASE_E: begin
          if (strobe) begin
            if (cr_release_step == '0 || cr_release_step >= level_q) begin
              level_d = '0;
              state_d = ENV_IDLE_E;
            end else begin
              level_d = level_q - cr_release_step;
            end
          end
        end
        default: begin
          level_d = '0;
          state_d = ENV_IDLE_E;
        end
      endcase
    end
  end

  // Envelope state registers; reset drops any note in progress immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q  <= 1'b0;
      state_q <= ENV_IDLE_E;
      level_q <= '0;
    end else begin
      gate_q  <= gate_d;
      state_q <= state_d;
      level_q <= level_d;
    end
  end

  assign env_level = level_q;
  assign env_state = state_q;

endmodule

// File: rtl/osc_envelope_vca.sv
// Enveloped amplifier: ADSR generator plus a two-stage signed multiply (VCA).
// Each sample is scaled by the envelope level held before that strobe's update.
module osc_envelope_vca
  import oscillator_types_pkg::*;
#(
  parameter int WAVE_WIDTH_P = 24,
  parameter int ENV_WIDTH_P  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WAVE_WIDTH_P-1:0] waveform_in,
  input  logic                    waveform_valid,
  input  logic                    gate,
  input  logic [ENV_WIDTH_P-1:0]  cr_attack_step,
  input  logic [ENV_WIDTH_P-1:0]  cr_decay_step,
  input  logic [ENV_WIDTH_P-1:0]  cr_sustain_level,
  input  logic [ENV_WIDTH_P-1:0]  cr_release_step,
  output logic [WAVE_WIDTH_P-1:0] waveform_out,
  output logic                    waveform_out_valid,
  output logic [ENV_WIDTH_P-1:0]  env_level,
  output logic [2:0]              env_state,
  output logic                    env_busy
);

  localparam int PROD_WIDTH_C = WAVE_WIDTH_P + ENV_WIDTH_P + 1;

  osc_env_state_t                  adsr_state;
  logic [ENV_WIDTH_P-1:0]          adsr_level;

  logic signed [PROD_WIDTH_C-1:0]  product_q;
  logic signed [PROD_WIDTH_C-1:0]  product_d;
  logic                            valid1_q;
  logic                            valid1_d;
  logic [WAVE_WIDTH_P-1:0]         wave_out_q;
  logic [WAVE_WIDTH_P-1:0]         wave_out_d;
  logic                            valid2_q;
  logic                            valid2_d;
  logic                            prod_unused;

  osc_adsr #(
    .ENV_WIDTH_P (ENV_WIDTH_P)
  ) u_adsr (
    .clk              (clk),
    .rst_n            (rst_n),
    .gate             (gate),
    .strobe           (waveform_valid),
    .cr_attack_step   (cr_attack_step),
    .cr_decay_step    (cr_decay_step),
    .cr_sustain_level (cr_sustain_level),
    .cr_release_step  (cr_release_step),
    .env_level        (adsr_level),
    .env_state        (adsr_state)
  );

  // Stage inputs: capture the product on a strobe, rescale it one clock later.
  always_comb begin
    valid1_d   = waveform_valid;
    product_d  = product_q;
    valid2_d   = valid1_q;
    wave_out_d = wave_out_q;
    if (waveform_valid) begin
      // Level is zero-extended so it multiplies as a positive gain.
      product_d = $signed(waveform_in) * $signed({1'b0, adsr_level});
    end
    if (valid1_q) begin
      // Slicing above the fraction bits equals an arithmetic shift (floor).
      wave_out_d = product_q[ENV_WIDTH_P +: WAVE_WIDTH_P];
    end
  end

  // Fraction bits and the spare sign bit are discarded by the rescale.
  assign prod_unused = ^{product_q[ENV_WIDTH_P-1:0], product_q[PROD_WIDTH_C-1]};

  // VCA pipeline registers; reset flushes any sample still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_q  <= '0;
      valid1_q   <= 1'b0;
      wave_out_q <= '0;
      valid2_q   <= 1'b0;
    end else begin
      product_q  <= product_d;
      valid1_q   <= valid1_d;
      wave_out_q <= wave_out_d;
      valid2_q   <= valid2_d;
    end
  end

  assign waveform_out       = wave_out_q;
  assign waveform_out_valid = valid2_q;
  assign env_level          = adsr_level;
  assign env_state          = adsr_state;
  assign env_busy           = env_state_active(adsr_state);

endmodule

// File: tb/tb_osc_envelope_vca.sv
// Bench for osc_envelope_vca: directed envelope walk-throughs followed by a
// long randomized run, all compared every clock against a behavioural model.
module tb_osc_envelope_vca;

  localparam int W    = 24;
  localparam int E    = 16;
  localparam int MAXL = 65535;
  // Envelope phases as plain numbers.
  localparam int P_IDLE = 0, P_ATT = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  waveform_in = '0;
  logic          waveform_valid = 1'b0;
  logic          gate = 1'b0;
  logic [E-1:0]  att = '0, dec = '0, sus = '0, rel = '0;
  logic [W-1:0]  waveform_out;
  logic          waveform_out_valid;
  logic [E-1:0]  env_level;
  logic [2:0]    env_state;
  logic          env_busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase, level, last gate, and the expected output stream.
  int     m_phase, m_level;
  bit     m_gate;
  bit     m_s1_valid, m_out_valid;
  longint m_s1_value, m_out_value;

  osc_envelope_vca dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .waveform_in        (waveform_in),
    .waveform_valid     (waveform_valid),
    .gate               (gate),
    .cr_attack_step     (att),
    .cr_decay_step      (dec),
    .cr_sustain_level   (sus),
    .cr_release_step    (rel),
    .waveform_out       (waveform_out),
    .waveform_out_valid (waveform_out_valid),
    .env_level          (env_level),
    .env_state          (env_state),
    .env_busy           (env_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_level = 0; m_gate = 1'b0;
    m_s1_valid = 1'b0; m_out_valid = 1'b0;
    m_s1_value = 0; m_out_value = 0;
  endtask

  // One clock of the model, using the inputs currently driven.
  task automatic model_clock();
    bit rise, fall;
    int a, d, s, r;
    if (!rst_n) return;
    a = int'(att); d = int'(dec); s = int'(sus); r = int'(rel);
    rise = gate && !m_gate;
    fall = !gate && m_gate;
    m_gate = gate;
    // Output path: value = floor(sample * level / 2^16), two clocks later.
    m_out_valid = m_s1_valid;
    if (m_s1_valid) m_out_value = m_s1_value;
    m_s1_valid = waveform_valid;
    if (waveform_valid)
      m_s1_value = (longint'($signed(waveform_in)) * m_level) >>> E;
    // Envelope rules.
    if (rise) begin
      m_phase = P_ATT;
    end else if (fall) begin
      if (m_phase == P_ATT || m_phase == P_DEC || m_phase == P_SUS) m_phase = P_REL;
    end else if (m_phase == P_SUS) begin
      m_level = s;
    end else if (waveform_valid) begin
      if (m_phase == P_ATT) begin
        if (a == 0 || m_level + a >= MAXL) begin m_level = MAXL; m_phase = P_DEC; end
        else m_level = m_level + a;
      end else if (m_phase == P_DEC) begin
        if (d == 0 || m_level - d <= s) begin m_level = s; m_phase = P_SUS; end
        else m_level = m_level - d;
      end else if (m_phase == P_REL) begin
        if (r == 0 || r >= m_level) begin m_level = 0; m_phase = P_IDLE; end
        else m_level = m_level - r;
      end
    end
  endtask

  task automatic compare_all();
    check("state", longint'(env_state), m_phase);
    check("level", longint'(env_level), m_level);
    check("busy", longint'(env_busy), (m_phase != P_IDLE) ? 1 : 0);
    check("out_valid", longint'(waveform_out_valid), m_out_valid ? 1 : 0);
    check("out", longint'($signed(waveform_out)), m_out_value);
  endtask

  // Drive one clock's inputs, advance the model, check at the falling edge.
  task automatic cycle(input bit v, input logic [W-1:0] w, input bit g);
    waveform_valid = v;
    waveform_in    = w;
    gate           = g;
    model_clock();
    @(negedge clk);
    compare_all();
  endtask

  // Asynchronous reset pulse away from any clock edge.
  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [E-1:0] pick_step();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return E'($urandom_range(1, 64));
      2:       return E'($urandom_range(1, 65535));
      3:       return E'(MAXL);
      default: return E'($urandom_range(1000, 8000));
    endcase
  endfunction

  initial begin
    int lv[8];
    int rl[3];
    bit g;
    bit burst;
    lv = '{16384, 32768, 49152, 65535, 57343, 49151, 40959, 40000};
    rl = '{25000, 10000, 0};

    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Idle with strobes running: outputs follow with zero level.
    for (int i = 0; i < 6; i++) cycle(1'b1, W'(1000 + i), 1'b0);
    check("idle_state", longint'(env_state), P_IDLE);

    // Full attack/decay walk.
    att = 16'd16384; dec = 16'd8192; sus = 16'd40000; rel = 16'd15000;
    cycle(1'b0, '0, 1'b1);
    check("rise_state", longint'(env_state), P_ATT);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, (i == 1) ? W'(-1000) : W'(1000), 1'b1);
      check("plan_lvl", longint'(env_level), lv[i]);
      if (i == 3) check("plan_decay", longint'(env_state), P_DEC);
      if (i == 7) check("plan_sustain", longint'(env_state), P_SUS);
      cycle(1'b0, '0, 1'b1);
      if (i == 1) check("plan_out_neg", longint'($signed(waveform_out)), -250);
      if (i == 2) check("plan_out_pos", longint'($signed(waveform_out)), 500);
      if (i == 2) check("plan_out_vld", longint'(waveform_out_valid), 1);
    end

    // Release to idle.
    cycle(1'b0, '0, 1'b0);
    check("rel_state", longint'(env_state), P_REL);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, W'(5), 1'b0);
      check("plan_rel", longint'(env_level), rl[i]);
    end
    check("rel_idle_busy", longint'(env_busy), 0);

    // Retrigger during release: the edge wins over a simultaneous strobe.
    att = 16'd20000;
    cycle(1'b0, '0, 1'b1);
    cycle(1'b1, W'(7), 1'b1);
    cycle(1'b0, '0, 1'b0);
    check("retrig_rel", longint'(env_state), P_REL);
    cycle(1'b1, W'(7), 1'b1);
    check("retrig_state", longint'(env_state), P_ATT);
    check("retrig_hold", longint'(env_level), 20000);
    cycle(1'b1, W'(7), 1'b1);
    check("retrig_next", longint'(env_level), 40000);

    // Zero steps are instantaneous; then reset mid-decay with data in flight.
    att = '0; dec = '0; rel = '0; sus = 16'd30000;
    cycle(1'b0, '0, 1'b0);
    cycle(1'b1, W'(9), 1'b0);
    check("zero_rel", longint'(env_level), 0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b1, W'(9), 1'b1);
    check("zero_att", longint'(env_level), MAXL);
    cycle(1'b1, W'(9), 1'b1);
    check("zero_dec", longint'(env_level), 30000);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b1, W'(9), 1'b1);
    check("pre_rst_dec", longint'(env_state), P_DEC);
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b1);
      check("rst_no_valid", longint'(waveform_out_valid), 0);
    end

    // Randomized run against the model.
    g = 1'b1;
    burst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) pulse_reset();
      if ($urandom_range(0, 29) == 0) g = ~g;
      if ($urandom_range(0, 149) == 0) att = pick_step();
      if ($urandom_range(0, 149) == 0) dec = pick_step();
      if ($urandom_range(0, 149) == 0) rel = pick_step();
      if ($urandom_range(0, 19) == 0) sus = E'($urandom);
      if ($urandom_range(0, 49) == 0) burst = ~burst;
      cycle(burst ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
            W'($urandom), g);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
